// File: rtl/procyon_wb_pkg.sv
// Shared Wishbone definitions for the procyon arbiter: FSM state encoding,
// cycle-type-identifier constants and a state-to-grant decode helper.
package procyon_wb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_M0   = 2'b01,
        ARB_M1   = 2'b10
    } arb_state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_INCR    = 3'b010;
    localparam logic [2:0] WB_CTI_END     = 3'b111;

    // One-hot owner vector for a given arbiter state (bit N = master N).
    function automatic logic [1:0] state_to_grant(input arb_state_t state);
        logic [1:0] grant;
        case (state)
            ARB_M0:  grant = 2'b01;
            ARB_M1:  grant = 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/procyon_wb_watchdog.sv
// Saturating bus-timeout counter. Counts cycles in which the owner strobes
// without an acknowledge; expired is high while the count sits at the last
// allowed value. A timeout of 0 disables the watchdog entirely.
module procyon_wb_watchdog #(
    parameter int unsigned OPTN_TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CNT_W = (OPTN_TIMEOUT_CYCLES > 0) ? $clog2(OPTN_TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OPTN_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((OPTN_TIMEOUT_CYCLES > 0) ? (OPTN_TIMEOUT_CYCLES - 1) : 0);
    localparam logic             ENABLED  = (OPTN_TIMEOUT_CYCLES != 0) ? 1'b1 : 1'b0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             expired_q;
    logic             expired_d;

    // Next count: clear wins, otherwise increment up to the saturation point.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q < CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        expired_d = ENABLED & (cnt_d == CNT_LAST);
    end

    // Counter and registered expiry flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/procyon_wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter. Registered round-robin grant on
// ties, ownership held for the whole cyc (bursts included), and a watchdog
// that aborts a transfer the slave never acknowledges.
module procyon_wb_arbiter
    import procyon_wb_pkg::*;
#(
    parameter int unsigned OPTN_WB_DATA_WIDTH  = 32,
    parameter int unsigned OPTN_WB_ADDR_WIDTH  = 32,
    parameter int unsigned OPTN_TIMEOUT_CYCLES = 64
) (
    input  logic                            i_wb_clk,
    input  logic                            i_wb_rst,

    input  logic                            i_m0_wb_cyc,
    input  logic                            i_m0_wb_stb,
    input  logic                            i_m0_wb_we,
    input  logic [2:0]                      i_m0_wb_cti,
    input  logic [1:0]                      i_m0_wb_bte,
    input  logic [OPTN_WB_DATA_WIDTH/8-1:0] i_m0_wb_sel,
    input  logic [OPTN_WB_ADDR_WIDTH-1:0]   i_m0_wb_addr,
    input  logic [OPTN_WB_DATA_WIDTH-1:0]   i_m0_wb_data,
    output logic [OPTN_WB_DATA_WIDTH-1:0]   o_m0_wb_data,
    output logic                            o_m0_wb_ack,
    output logic                            o_m0_wb_err,

    input  logic                            i_m1_wb_cyc,
    input  logic                            i_m1_wb_stb,
    input  logic                            i_m1_wb_we,
    input  logic [2:0]                      i_m1_wb_cti,
    input  logic [1:0]                      i_m1_wb_bte,
    input  logic [OPTN_WB_DATA_WIDTH/8-1:0] i_m1_wb_sel,
    input  logic [OPTN_WB_ADDR_WIDTH-1:0]   i_m1_wb_addr,
    input  logic [OPTN_WB_DATA_WIDTH-1:0]   i_m1_wb_data,
    output logic [OPTN_WB_DATA_WIDTH-1:0]   o_m1_wb_data,
    output logic                            o_m1_wb_ack,
    output logic                            o_m1_wb_err,

    output logic                            o_s_wb_cyc,
    output logic                            o_s_wb_stb,
    output logic                            o_s_wb_we,
    output logic [2:0]                      o_s_wb_cti,
    output logic [1:0]                      o_s_wb_bte,
    output logic [OPTN_WB_DATA_WIDTH/8-1:0] o_s_wb_sel,
    output logic [OPTN_WB_ADDR_WIDTH-1:0]   o_s_wb_addr,
    output logic [OPTN_WB_DATA_WIDTH-1:0]   o_s_wb_data,
    input  logic [OPTN_WB_DATA_WIDTH-1:0]   i_s_wb_data,
    input  logic                            i_s_wb_ack,

    output logic [1:0]                      o_grant
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_grant_q;   // 0: master 0 owned last, 1: master 1 owned last
    logic       last_grant_d;
    logic [1:0] grant_q;
    logic [1:0] grant_d;

    logic own_m0_s;
    logic own_m1_s;
    logic owned_s;
    logic own_stb_s;
    logic expired_s;
    logic timeout_s;
    logic wd_clear_s;
    logic wd_count_en_s;

    assign own_m0_s  = (state_q == ARB_M0);
    assign own_m1_s  = (state_q == ARB_M1);
    assign owned_s   = own_m0_s | own_m1_s;
    assign own_stb_s = (own_m0_s & i_m0_wb_stb) | (own_m1_s & i_m1_wb_stb);
    // An acknowledge in the same cycle as expiry completes the transfer normally.
    assign timeout_s = owned_s & expired_s & ~i_s_wb_ack;

    // Arbitration: pick an owner from idle, hold it while its cyc stays high.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_m0_wb_cyc && i_m1_wb_cyc) begin
                    state_d = last_grant_q ? ARB_M0 : ARB_M1;
                end else if (i_m0_wb_cyc) begin
                    state_d = ARB_M0;
                end else if (i_m1_wb_cyc) begin
                    state_d = ARB_M1;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_M0: begin
                if (timeout_s) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = 1'b0;
                end else if (!i_m0_wb_cyc) begin
                    state_d      = i_m1_wb_cyc ? ARB_M1 : ARB_IDLE;
                    last_grant_d = 1'b0;
                end else begin
                    state_d = ARB_M0;
                end
            end
            ARB_M1: begin
                if (timeout_s) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = 1'b1;
                end else if (!i_m1_wb_cyc) begin
                    state_d      = i_m0_wb_cyc ? ARB_M0 : ARB_IDLE;
                    last_grant_d = 1'b1;
                end else begin
                    state_d = ARB_M1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        grant_d = state_to_grant(state_d);
    end

    // Arbiter state, last owner and registered grant vector.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    assign wd_clear_s    = ~owned_s | i_s_wb_ack | ~own_stb_s | (state_d != state_q);
    assign wd_count_en_s = owned_s & own_stb_s & ~i_s_wb_ack;

    procyon_wb_watchdog #(
        .OPTN_TIMEOUT_CYCLES (OPTN_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (i_wb_clk),
        .rst      (i_wb_rst),
        .clear    (wd_clear_s),
        .count_en (wd_count_en_s),
        .expired  (expired_s)
    );

    // Slave-side mux: pass the owner straight through, quiet bus otherwise.
    always_comb begin
        o_s_wb_cyc  = 1'b0;
        o_s_wb_stb  = 1'b0;
        o_s_wb_we   = 1'b0;
        o_s_wb_cti  = WB_CTI_CLASSIC;
        o_s_wb_bte  = 2'b00;
        o_s_wb_sel  = '0;
        o_s_wb_addr = '0;
        o_s_wb_data = '0;
        if (own_m0_s) begin
            o_s_wb_cyc  = i_m0_wb_cyc & ~timeout_s;
            o_s_wb_stb  = i_m0_wb_stb & ~timeout_s;
            o_s_wb_we   = i_m0_wb_we;
            o_s_wb_cti  = i_m0_wb_cti;
            o_s_wb_bte  = i_m0_wb_bte;
            o_s_wb_sel  = i_m0_wb_sel;
            o_s_wb_addr = i_m0_wb_addr;
            o_s_wb_data = i_m0_wb_data;
        end else if (own_m1_s) begin
            o_s_wb_cyc  = i_m1_wb_cyc & ~timeout_s;
            o_s_wb_stb  = i_m1_wb_stb & ~timeout_s;
            o_s_wb_we   = i_m1_wb_we;
            o_s_wb_cti  = i_m1_wb_cti;
            o_s_wb_bte  = i_m1_wb_bte;
            o_s_wb_sel  = i_m1_wb_sel;
            o_s_wb_addr = i_m1_wb_addr;
            o_s_wb_data = i_m1_wb_data;
        end else begin
            o_s_wb_cyc = 1'b0;
        end
    end

    assign o_m0_wb_data = i_s_wb_data;
    assign o_m1_wb_data = i_s_wb_data;
    assign o_m0_wb_ack  = own_m0_s & i_s_wb_ack;
    assign o_m1_wb_ack  = own_m1_s & i_s_wb_ack;
    assign o_m0_wb_err  = own_m0_s & timeout_s;
    assign o_m1_wb_err  = own_m1_s & timeout_s;
    assign o_grant      = grant_q;

endmodule
